// File: rtl/dequant_pkg.sv
// Shared constants, state type and bits-code decoding for the sample dequantizer.
package dequant_pkg;

  localparam logic [2:0] BITS_1   = 3'd1;
  localparam logic [2:0] BITS_2   = 3'd2;
  localparam logic [2:0] BITS_3   = 3'd3;
  localparam logic [2:0] BITS_4   = 3'd4;
  localparam logic [2:0] BITS_RAW = 3'd6;
  localparam logic [2:0] BITS_8   = 3'd7;

  typedef enum logic {IDLE, UNPACK} state_t;

  // A width of zero marks a bits code that the quantizer never produces.
  function automatic logic [5:0] code_width(input logic [2:0] bits);
    case (bits)
      BITS_1:   code_width = 6'd1;
      BITS_2:   code_width = 6'd2;
      BITS_3:   code_width = 6'd3;
      BITS_4:   code_width = 6'd4;
      BITS_8:   code_width = 6'd8;
      BITS_RAW: code_width = 6'd32;
      default:  code_width = 6'd0;
    endcase
  endfunction

  function automatic logic [5:0] codes_per_word(input logic [2:0] bits);
    case (bits)
      BITS_1:   codes_per_word = 6'd32;
      BITS_2:   codes_per_word = 6'd16;
      BITS_3:   codes_per_word = 6'd10;
      BITS_4:   codes_per_word = 6'd8;
      BITS_8:   codes_per_word = 6'd4;
      BITS_RAW: codes_per_word = 6'd1;
      default:  codes_per_word = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/dequant_recon.sv
// Combinational reconstruction of the code sitting in the top w bits of sh.
// Build option SAMPLE_DEQUANTIZER_MIDPOINT_EN selects mid-rise reconstruction.
module dequant_recon #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] sh,
  input  logic [5:0]        w,
  output logic [DATA_W-1:0] recon
);

  logic [DATA_W-1:0] keep_mask;

  // Keep the top w bits; a full-width code (raw mode) passes untouched.
  always_comb begin
    keep_mask = ~({DATA_W{1'b1}} >> w);
    recon     = sh & keep_mask;
`ifdef SAMPLE_DEQUANTIZER_MIDPOINT_EN
    if (w < 6'd32)
      recon = recon | ({1'b1, {(DATA_W-1){1'b0}}} >> w);
`endif
  end

endmodule

// File: rtl/sample_dequantizer.sv
// Unpacks MSB-first N-bit codes from 32-bit words into reconstructed samples.
// Optional mid-rise reconstruction: define SAMPLE_DEQUANTIZER_MIDPOINT_EN.
module sample_dequantizer
  import dequant_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] inp,
  input  logic [2:0]        bits,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] outp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              last,
  output logic              err
);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sh;
  logic [5:0]        w;
  logic [5:0]        cnt;
  logic              err_q;
  logic [DATA_W-1:0] recon;
  logic              accept;
  logic              word_ok;
  logic              fire;

  assign accept  = (state == IDLE) && in_valid;
  assign word_ok = (code_width(bits) != 6'd0);
  assign fire    = (state == UNPACK) && out_ready;

  dequant_recon #(.DATA_W(DATA_W)) u_recon (
    .sh    (sh),
    .w     (w),
    .recon (recon)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && word_ok) state_nxt = UNPACK;
      UNPACK:  if (fire && cnt == 6'd1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bits is only looked at on acceptance; the latched width drives the whole word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh    <= '0;
      w     <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !word_ok;
      if (accept && word_ok) begin
        sh  <= inp;
        w   <= code_width(bits);
        cnt <= codes_per_word(bits);
      end else if (fire) begin
        sh  <= sh << w;
        cnt <= cnt - 6'd1;
      end
    end
  end

  // Gate outp by state so leftover low bits (e.g. the two unused bits at N=3) never leak out.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == UNPACK);
    last      = (state == UNPACK) && (cnt == 6'd1);
    outp      = (state == UNPACK) ? recon : '0;
    err       = err_q;
  end

endmodule

// File: tb/tb_sample_dequantizer.sv
// Scoreboard bench: a word-level model queues expected samples, a monitor pops them on handshakes.
module tb_sample_dequantizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inp = '0;
  logic [2:0]  bits = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] outp;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        last;
  logic        err;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  bit   force_low = 1'b0;
  bit   rand_en = 1'b0;

  sample_dequantizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inp       (inp),
    .bits      (bits),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .outp      (outp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .last      (last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  function automatic int model_width(input logic [2:0] b);
    case (b)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 3;
      3'd4: return 4;
      3'd7: return 8;
      3'd6: return 32;
      default: return 0;
    endcase
  endfunction

  // Expected samples of one word: slice codes arithmetically from the top down.
  task automatic push_model(input logic [31:0] word, input logic [2:0] b);
    int n;
    int k;
    logic [31:0] code;
    logic [31:0] val;
    n = model_width(b);
    if (n == 32) begin
      q.push_back('{word, 1'b1});
    end else begin
      k = 32 / n;
      for (int i = 0; i < k; i++) begin
        code = (word >> (32 - n * (i + 1))) & ((32'd1 << n) - 32'd1);
        val  = code << (32 - n);
`ifdef SAMPLE_DEQUANTIZER_MIDPOINT_EN
        val  = val | (32'd1 << (31 - n));
`endif
        q.push_back('{val, (i == k - 1)});
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] word, input logic [2:0] b);
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: actual in_ready=%b required 1", in_ready);
    end
    inp      = word;
    bits     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (model_width(b) == 0) begin
      checkOutput("err_pulse", {31'b0, err}, 32'd1);
      checkOutput("err_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("err_noval", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("err_once", {31'b0, err}, 32'd0);
    end else begin
      push_model(word, b);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(q.size() == 0 && in_ready) && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!(q.size() == 0 && in_ready)) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: actual pending=%0d required 0", q.size());
    end
  endtask

  task automatic wait_pops(input int target);
    int t;
    t = 0;
    while (pops < target && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (pops < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL pop_timeout: actual %0d required %0d", pops, target);
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = force_low ? 1'b0 : (rand_en ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Monitor: every completed handshake must match the oldest expected sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_sample: actual %h required none", outp);
      end else begin
        exp_t e;
        e = q.pop_front();
        checkOutput("sample", outp, e.data);
        checkOutput("last", {31'b0, last}, {31'b0, e.last});
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [2:0] rb;
    #12;
    checkOutput("rst_outp", outp, 32'd0);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_last", {31'b0, last}, 32'd0);
    checkOutput("rst_err", {31'b0, err}, 32'd0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(32'hA000_0000, 3'd1);
    drain();

    base = pops;
    applyStimulus(32'h1234_5678, 3'd4);
    checkOutput("busy", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("latency", {31'b0, out_valid}, 32'd1);
    wait_pops(base + 8);
    @(posedge clk);
    #1;
    checkOutput("ready_after_last", {31'b0, in_ready}, 32'd1);
    drain();

    applyStimulus(32'hFFFF_FFFF, 3'd3);
    drain();
    applyStimulus(32'hDEAD_BEEF, 3'd6);
    drain();

    force_low = 1'b1;
    @(posedge clk);
    #2;
    applyStimulus(32'h1122_3344, 3'd7);
    for (int i = 0; i < 3; i++) begin
      bits = 3'($urandom_range(0, 7));
      @(negedge clk);
`ifdef SAMPLE_DEQUANTIZER_MIDPOINT_EN
      checkOutput("stall_hold", outp, 32'h1180_0000);
`else
      checkOutput("stall_hold", outp, 32'h1100_0000);
`endif
      checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
    end
    force_low = 1'b0;
    drain();

    applyStimulus(32'h5555_AAAA, 3'd5);
    applyStimulus(32'h0F0F_0F0F, 3'd0);

    base = pops;
    applyStimulus(32'h9C3A_71E5, 3'd2);
    wait_pops(base + 2);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_outp", outp, 32'd0);
    checkOutput("midrst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrst_ready", {31'b0, in_ready}, 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(32'hC001_D00D, 3'd2);
    drain();

    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rb = 3'($urandom_range(0, 7));
      applyStimulus($urandom, rb);
    end
    drain();
    rand_en = 1'b0;

    checkOutput("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
